// File: rtl/noc_pkg.sv
// Shared definitions for the NoC memory bridge: flit types, head-field layout and FSM states.
// The ACK state exists only when NOC_MEM_BRIDGE_WRITE_ACK_EN is defined.
package noc_pkg;

   localparam int FLIT_W = 34;

   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   // Head payload bit positions (LSB of each field)
   localparam int HF_DEST_LSB = 30;
   localparam int HF_SRC_LSB  = 28;
   localparam int HF_CMD_BIT  = 27;
   localparam int HF_BE_LSB   = 23;
   localparam int HF_ADDR_LSB = 13;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WDATA    = 3'd1,
      ST_WR_ISSUE = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RSP_HEAD = 3'd5,
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
      ST_RSP_DATA = 3'd6,
      ST_ACK      = 3'd7
`else
      ST_RSP_DATA = 3'd6
`endif
   } state_t;

endpackage

// File: rtl/noc_flit_out_reg.sv
// Single-entry response flit holding register: once valid, the flit stays put
// until the router takes it; a load in the handshake cycle replaces it directly.
module noc_flit_out_reg
   import noc_pkg::*;
#(
   parameter int W = FLIT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_flit,
   input  logic         out_ready,
   output logic [W-1:0] out_flit,
   output logic         out_valid
);

   logic [W-1:0] flit_reg;
   logic         valid_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flit_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         flit_reg  <= load_flit;
         valid_reg <= 1'b1;
      end else if (valid_reg && out_ready) begin
         flit_reg  <= '0;
         valid_reg <= 1'b0;
      end
   end

   assign out_flit  = flit_reg;
   assign out_valid = valid_reg;

endmodule

// File: rtl/noc_mem_bridge.sv
// NoC-to-memory bridge: decodes request packets, drives Avalon-style memory cycles, returns read data.
// Define NOC_MEM_BRIDGE_WRITE_ACK_EN to send a head+tail acknowledge flit after each write.
module noc_mem_bridge
   import noc_pkg::*;
#(
   parameter logic [1:0] NODE_ID = 2'd0,
   parameter int         ADDR_W  = 10,
   parameter int         DATA_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W+1:0]   in_flit,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DATA_W+1:0]   out_flit,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int FW   = DATA_W + 2;
   localparam int BE_W = DATA_W / 8;

   state_t              state_reg, state_next;
   logic [1:0]          src_reg, src_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [BE_W-1:0]     be_reg, be_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [DATA_W-1:0]   rdata_reg, rdata_next;

   logic                load;
   logic [FW-1:0]       load_flit;
   logic [FW-1:0]       rsp_head;
   logic                in_fire, out_fire;
   logic [1:0]          in_type;
   logic                hd_is_rd, hd_is_wr, hd_latch;

   assign in_ready = (state_reg == ST_IDLE) || (state_reg == ST_WDATA);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // A well-formed read is a single head+tail flit; a write opens with a head-only flit.
   assign in_type  = in_flit[DATA_W +: 2];
   assign hd_is_rd = (in_type == FT_SINGLE) && !in_flit[HF_CMD_BIT];
   assign hd_is_wr = (in_type == FT_HEAD) && in_flit[HF_CMD_BIT];
   assign hd_latch = in_fire && (hd_is_rd || hd_is_wr);

   always_comb begin
      rsp_head                           = '0;
      rsp_head[DATA_W +: 2]              = FT_HEAD;
      rsp_head[HF_DEST_LSB +: 2]         = src_reg;
      rsp_head[HF_SRC_LSB +: 2]          = NODE_ID;
      rsp_head[HF_BE_LSB +: BE_W]        = be_reg;
      rsp_head[HF_ADDR_LSB +: ADDR_W]    = addr_reg;
   end

   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      addr_next  = addr_reg;
      be_next    = be_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      load       = 1'b0;
      load_flit  = '0;

      if (hd_latch) begin
         src_next  = in_flit[HF_SRC_LSB +: 2];
         addr_next = in_flit[HF_ADDR_LSB +: ADDR_W];
         be_next   = in_flit[HF_BE_LSB +: BE_W];
      end

      case (state_reg)
         ST_IDLE: begin
            if (in_fire && hd_is_rd)
               state_next = ST_RD_ISSUE;
            else if (in_fire && hd_is_wr)
               state_next = ST_WDATA;
         end
         ST_WDATA: begin
            // A new head here abandons the pending write and is decoded afresh.
            if (in_fire) begin
               if (in_type == FT_TAIL) begin
                  wdata_next = in_flit[DATA_W-1:0];
                  state_next = ST_WR_ISSUE;
               end else if (hd_is_rd)
                  state_next = ST_RD_ISSUE;
               else if (hd_is_wr)
                  state_next = ST_WDATA;
               else if (in_type != FT_BODY)
                  state_next = ST_IDLE;
            end
         end
         ST_WR_ISSUE: begin
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
            load_flit                  = rsp_head;
            load_flit[DATA_W +: 2]     = FT_SINGLE;
            load_flit[HF_CMD_BIT]      = 1'b1;
            load                       = 1'b1;
            state_next                 = ST_ACK;
`else
            state_next = ST_IDLE;
`endif
         end
         ST_RD_ISSUE: state_next = ST_RD_WAIT;
         ST_RD_WAIT: begin
            rdata_next = mem_readdata;
            load       = 1'b1;
            load_flit  = rsp_head;
            state_next = ST_RSP_HEAD;
         end
         ST_RSP_HEAD: begin
            if (out_fire) begin
               load       = 1'b1;
               load_flit  = {FT_TAIL, rdata_reg};
               state_next = ST_RSP_DATA;
            end
         end
         ST_RSP_DATA: begin
            if (out_fire)
               state_next = ST_IDLE;
         end
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
         ST_ACK: begin
            if (out_fire)
               state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         src_reg   <= '0;
         addr_reg  <= '0;
         be_reg    <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         src_reg   <= src_next;
         addr_reg  <= addr_next;
         be_reg    <= be_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
      end
   end

   // Memory strobes are registered from the next state so they line up with the issue states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_clken      <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_writedata  <= '0;
      end else begin
         mem_clken      <= 1'b1;
         mem_chipselect <= (state_next == ST_WR_ISSUE) || (state_next == ST_RD_ISSUE);
         mem_write      <= (state_next == ST_WR_ISSUE);
         if (state_next == ST_WR_ISSUE) begin
            mem_address    <= addr_next;
            mem_byteenable <= be_next;
            mem_writedata  <= wdata_next;
         end else if (state_next == ST_RD_ISSUE) begin
            mem_address    <= addr_next;
            mem_byteenable <= '1;
            mem_writedata  <= '0;
         end else begin
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            if (state_next != ST_RD_WAIT)
               mem_address <= '0;
         end
      end
   end

   noc_flit_out_reg #(
      .W(FW)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_flit (load_flit),
      .out_ready (out_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid)
   );

endmodule

// File: tb/tb_noc_mem_bridge.sv
// Scoreboard bench for noc_mem_bridge: directed scenarios plus randomized traffic against a word-level memory model.
`timescale 1ns/1ps
module tb_noc_mem_bridge;

   localparam logic [1:0] NODE_ID = 2'd1;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int FW = DW + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [FW-1:0] in_flit = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [FW-1:0] out_flit;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int writes_exp = 0;
   int last_wr_cyc = -1;
   logic bp_rand = 1'b0;
   logic or_fixed = 1'b1;

   logic [FW-1:0] exp_q[$];
   logic [DW-1:0] ref_mem [int];
   int            wr_addrs[$];

   noc_mem_bridge #(.NODE_ID(NODE_ID), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Synchronous single-port memory with byte lanes and one cycle of read latency
   logic [DW-1:0] env_mem [1024];
   logic [DW-1:0] env_word;
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            env_word = env_mem[mem_address];
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) env_word[8*b +: 8] = mem_writedata[8*b +: 8];
            env_mem[mem_address] <= env_word;
         end
         mem_readdata <= env_mem[mem_address];
      end
   end

   always @(posedge clk) begin
      #2;
      out_ready = bp_rand ? ($urandom_range(0, 9) < 7) : or_fixed;
   end

   // Monitor: pops the scoreboard on every response handshake, and polices hold-stable behaviour
   logic [FW-1:0] prev_flit = '0;
   logic [FW-1:0] exp_flit;
   logic          prev_hold = 1'b0;
   always @(negedge clk) begin
      if (reset) prev_hold = 1'b0;
      else begin
         if (mem_write) begin wr_pulses++; last_wr_cyc = cyc; end
         if (prev_hold) begin
            checks++;
            if (!out_valid || out_flit !== prev_flit) begin
               failures++;
               $display("FAIL hold_stable: got valid=%b flit=%h required valid=1 flit=%h", out_valid, out_flit, prev_flit);
            end
         end
         if (out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL in_ready_busy: got in_ready=%b required 0 while response pending", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_flit: got %h with no response expected", out_flit);
            end else begin
               exp_flit = exp_q.pop_front();
               if (out_flit !== exp_flit) begin
                  failures++;
                  $display("FAIL rsp_flit: got %h required %h", out_flit, exp_flit);
               end else
                  $display("rsp flit %h ok (cycle %0d)", out_flit, cyc);
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
               if (exp_flit[FW-1 -: 2] == 2'b11) begin
                  checks++;
                  if (!(last_wr_cyc >= 0 && last_wr_cyc < cyc)) begin
                     failures++;
                     $display("FAIL ack_order: ack at cycle %0d, last mem_write at %0d", cyc, last_wr_cyc);
                  end
               end
`endif
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_flit = out_flit;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [FW-1:0] make_head(input logic [1:0] ft, input logic [1:0] dest,
         input logic [1:0] src, input logic cmd, input logic [3:0] be, input logic [9:0] addr);
      return {ft, dest, src, cmd, be, addr, 13'd0};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
         input logic [3:0] be);
      logic [DW-1:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~mask) | (data & mask);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_flit"}, 64'(out_flit), 64'd0);
      check({tag, "_mem_cs"}, 64'(mem_chipselect), 64'd0);
      check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_address), 64'd0);
      check({tag, "_mem_be"}, 64'(mem_byteenable), 64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_writedata), 64'd0);
      check({tag, "_mem_clken"}, 64'(mem_clken), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   task automatic send_flit(input logic [FW-1:0] f);
      int n;
      logic ok;
      @(posedge clk); #1;
      in_flit = f;
      in_valid = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1; else n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_flit = '0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept: in_ready never asserted for flit %h", f);
      end
   endtask

   task automatic do_write(input logic [1:0] src, input logic [9:0] addr, input logic [3:0] be,
         input logic [DW-1:0] data);
      logic [DW-1:0] old;
      old = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
      ref_mem[int'(addr)] = merge(old, data, be);
      if (!ref_mem.exists(int'(addr)) || old == old) wr_addrs.push_back(int'(addr));
      writes_exp++;
      $display("write src=%0d addr=%h be=%b data=%h", src, addr, be, data);
      send_flit(make_head(2'b01, NODE_ID, src, 1'b1, be, addr));
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
      exp_q.push_back(make_head(2'b11, src, NODE_ID, 1'b1, be, addr));
`endif
      send_flit({2'b10, data});
   endtask

   task automatic do_read(input logic [1:0] src, input logic [9:0] addr, input logic [3:0] be);
      int n;
      logic seen;
      exp_q.push_back(make_head(2'b01, src, NODE_ID, 1'b0, be, addr));
      exp_q.push_back({2'b10, ref_mem[int'(addr)]});
      $display("read  src=%0d addr=%h be=%b expect=%h", src, addr, be, ref_mem[int'(addr)]);
      send_flit(make_head(2'b11, NODE_ID, src, 1'b0, be, addr));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1'b1;
      end
      check("read_latency", 64'(n), 64'd3);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [FW-1:0] held;
      int wr_before;
      logic [9:0] a;
      logic [3:0] be;

      // Reset state
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("clken_after_reset", 64'(mem_clken), 64'd1);
      check("in_ready_idle", 64'(in_ready), 64'd1);

      // Write-then-read
      do_write(2'd2, 10'h005, 4'hF, 32'hDEADBEEF);
      do_read(2'd2, 10'h005, 4'hF);
      wait_drain();

      // Byte-lane merge
      do_write(2'd0, 10'h010, 4'hF, 32'h11223344);
      do_write(2'd0, 10'h010, 4'b0010, 32'h0000AA00);
      check("byte_lane_model", 64'(ref_mem[16]), 64'h1122AA44);
      do_read(2'd3, 10'h010, 4'hF);
      wait_drain();

      // Backpressure during RSP_HEAD
      or_fixed = 1'b0;
      do_read(2'd1, 10'h005, 4'hA);
      held = out_flit;
      repeat (5) begin
         @(negedge clk);
         check("bp_flit_stable", 64'(out_flit), 64'(held));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      or_fixed = 1'b1;
      wait_drain();

      // Protocol errors: stray body, malformed heads, abandoned write
      wr_before = wr_pulses;
      send_flit({2'b00, 32'h12345678});
      send_flit(make_head(2'b11, NODE_ID, 2'd1, 1'b1, 4'hF, 10'h040));
      send_flit(make_head(2'b01, NODE_ID, 2'd1, 1'b0, 4'hF, 10'h040));
      send_flit(make_head(2'b01, NODE_ID, 2'd3, 1'b1, 4'hF, 10'h005));
      do_read(2'd1, 10'h005, 4'hF);
      wait_drain();
      check("proto_no_write", 64'(wr_pulses), 64'(wr_before));

      // Reset during RD_WAIT drops the read
      do_write(2'd2, 10'h3FF, 4'hF, $urandom);
      do_write(2'd2, 10'h123, 4'hF, $urandom);
      send_flit(make_head(2'b11, NODE_ID, 2'd2, 1'b0, 4'hF, 10'h123));
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_rd_wait");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("post_reset_no_rsp", 64'(out_valid), 64'd0);
      end
      do_read(2'd0, 10'h3FF, 4'hF);
      wait_drain();

`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
      wr_before = wr_pulses;
      do_write(2'd3, 10'h020, 4'hF, 32'hCAFEF00D);
      wait_drain();
      check("ack_single_write", 64'(wr_pulses - wr_before), 64'd1);
`endif

      // Randomized traffic with random backpressure
      bp_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) begin
               a = 10'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
               be = 4'($urandom_range(1, 15));
            end else begin
               a = 10'($urandom_range(0, 1023));
               be = 4'hF;
            end
            do_write(2'($urandom_range(0, 3)), a, be, $urandom);
         end else begin
            a = 10'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
            do_read(2'($urandom_range(0, 3)), a, 4'($urandom_range(0, 15)));
         end
      end
      wait_drain();
      bp_rand = 1'b0;
      repeat (4) @(negedge clk);

      check("write_pulse_count", 64'(wr_pulses), 64'(writes_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_mem_bridge.md
Name: noc_mem_bridge

Overview:
- NoC-to-memory bridge placed directly upstream of the node's 1024x32 single-port data memory.
- Accepts request packets from the local router port and issues Avalon-style read/write cycles to the memory.
- Returns read data to the requester as a two-flit response packet.
- Serves one request at a time. Sequential throughout: FSM, registered memory strobes, 1-cycle read-latency capture, valid/ready flit handshakes.

Parameters:
- NODE_ID, 0, 2-bit ID of this node in the 2x2 mesh; written into the response src field.
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory data width; flit width is DATA_W+2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_flit  in  34  request flit; [33:32] type (01 head, 00 body, 10 tail, 11 head+tail)
- in_valid  in  1  request flit valid
- in_ready  out  1  bridge accepts in_flit this cycle
- out_flit  out  34  response flit, same format as in_flit
- out_valid  out  1  response flit valid
- out_ready  in  1  router accepts out_flit
- mem_address  out  10  memory word address
- mem_byteenable  out  4  byte lanes
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  write data
- mem_clken  out  1  memory clock enable; constant 1 after reset release
- mem_readdata  in  32  memory read data, valid 1 cycle after address is registered

Behaviour:
- Clock and reset: clk is the only clock. reset is asynchronous and active-high.
- Head payload fields: [31:30] dest, [29:28] src, [27] cmd (1 = write), [26:23] byteenable, [22:13] word address, [12:0] reserved (0).
- Read request: single head+tail flit.
- Write request: head flit, then one tail flit carrying the write data.
- Reset values: all outputs 0, except in_ready = 1 once in IDLE; mem_clken = 0 during reset. Async reset at any point returns to IDLE, drops the in-flight packet and asserts no memory strobe.
- FSM states: IDLE, WDATA, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP_HEAD, RSP_DATA (plus ACK when the optional feature is enabled).
- IDLE: in_ready = 1. On an accepted flit:
  - type 11 with cmd = 0: latch src, address and byteenable, go to RD_ISSUE.
  - type 01 with cmd = 1: latch the same fields, go to WDATA.
  - any other combination (body/tail in IDLE, read marked 01, write marked 11): drop the flit and stay in IDLE.
- WDATA: in_ready = 1.
  - Tail flit accepted: latch data, go to WR_ISSUE.
  - Head flit arriving here: drop the current packet and reprocess the new head as in IDLE.
- WR_ISSUE: drive chipselect = 1, write = 1, address, byteenable, writedata for exactly one cycle, then go to IDLE. Writes are posted.
- RD_ISSUE: drive chipselect = 1, write = 0, address, byteenable = 4'hF for one cycle, then go to RD_WAIT.
- RD_WAIT: hold address with chipselect = 0. Capture mem_readdata at the end of this cycle, then go to RSP_HEAD.
- Read latency, request accept to out_valid: 3 cycles.
- RSP_HEAD: out_flit = {01, dest = latched src, src = NODE_ID, cmd = 0, byteenable, address, 0}. Advance to RSP_DATA on out_valid & out_ready.
- RSP_DATA: out_flit = {10, captured data}. On handshake go to IDLE.
- Backpressure: while out_valid & !out_ready, out_flit is held stable and in_ready = 0.
- in_ready = 0 in every state except IDLE and WDATA.
- Address wrap: none. The full 10-bit address is used; 0x3FF is the last word.

Optional Feature:
- Macro: NOC_MEM_BRIDGE_WRITE_ACK_EN.
- Defined: WR_ISSUE goes to ACK instead of IDLE. ACK sends one head+tail flit {11, dest = src, src = NODE_ID, cmd = 1, byteenable, address, 0} with the same backpressure rules, then returns to IDLE.
- Undefined: writes are posted, no response is sent, and the ACK state is absent.

Decomposition:
- Shared package noc_pkg holds:
  - flit-type localparams (FT_BODY, FT_HEAD, FT_TAIL, FT_SINGLE);
  - head-field bit-position constants;
  - FLIT_W;
  - the FSM state encoding.
- One natural sub-module: noc_flit_out_reg, a single-entry output holding register implementing the valid/ready hold-stable rule. Head decode stays inline.

Test Plan:
- Write-then-read: write to addr 0x005, be = 4'hF, data 0xDEADBEEF, src = 2. Then read 0x005 from src = 2 → head dest = 2, src = NODE_ID; tail data 0xDEADBEEF; out_valid exactly 3 cycles after read accept.
- Byte-lane write: preload 0x010 = 0x11223344, then write be = 4'b0010, data 0x0000AA00 → read returns 0x1122AA44.
- Backpressure: out_ready low for 5 cycles during RSP_HEAD → out_flit unchanged, in_ready = 0 throughout, then both flits delivered in order.
- Protocol error: body flit in IDLE, then a write head followed by a new read head before the tail → no mem_write pulse, and the read is serviced normally.
- Reset mid-read: assert reset during RD_WAIT → all outputs 0, no response flit; after release, a read of 0x3FF completes.
- With NOC_MEM_BRIDGE_WRITE_ACK_EN: write to 0x020 → exactly one type-11 flit with cmd = 1, address 0x020, emitted after the single mem_write pulse.
